prediction_buffer: RTL and testbench
====================================

PREDICTION_BUFFER -- requirements
Module: prediction_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter OUT_W, default 16, signed width of the saturated output sample.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream regression result y is valid this cycle.
REQ-006 in_y  input  32  signed prediction from the linear-regression stage.
REQ-007 in_ready  output  1  buffer can accept a sample this cycle.
REQ-008 out_valid  output  1  head sample available.
REQ-009 out_ready  input  1  downstream consumes the head sample this cycle.
REQ-010 out_y  output  OUT_W  signed saturated head sample.
REQ-011 out_sat  output  1  head sample was clipped during saturation.
REQ-012 count  output  log2(DEPTH)+1  number of stored samples.

Function
REQ-013 Push SHALL occur when in_valid and in_ready are both high at a rising clk edge; pop SHALL occur when out_valid and out_ready are both high.
REQ-014 in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (count != 0); no bypass, so a sample pushed into an empty buffer appears on out_y exactly one cycle after the push edge.
REQ-016 Saturation on push: in_y > 2^(OUT_W-1)-1 stores 2^(OUT_W-1)-1 with sat=1; in_y < -2^(OUT_W-1) stores -2^(OUT_W-1) with sat=1; otherwise stores in_y[OUT_W-1:0] with sat=0.
REQ-017 out_y and out_sat SHALL present the head entry when out_valid=1, and SHALL be 0 when out_valid=0.
REQ-018 Simultaneous push and pop with 0<count<DEPTH: both SHALL take effect, count unchanged, ordering preserved.
REQ-019 When full, in_valid SHALL be ignored (no overwrite) even if a pop occurs in the same cycle.
REQ-020 When empty, out_ready SHALL have no effect; count SHALL NOT underflow.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strict first-in-first-out.
REQ-022 in_y SHALL be sampled only on a push edge; changes at other times SHALL have no effect.

Reset
REQ-023 While rst_n=0: count=0, pointers=0, out_valid=0, in_ready=1, out_y=0, out_sat=0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard all stored samples; the first push after deassertion SHALL be the first sample popped.
REQ-025 Storage array contents need not be reset; outputs are masked per REQ-017.

Configuration
REQ-026 Macro PRED_SATCNT_EN: when defined, add output sat_count (16 bits), which increments by one on every push with sat=1, holds at 65535 without wrapping, and resets to 0 with rst_n.
REQ-027 When PRED_SATCNT_EN is undefined, the sat_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then push in_y=1000 with out_ready=0 -> next cycle out_valid=1, out_y=1000, out_sat=0, count=1.
REQ-029 Push 5000000, then -5000000, then -500 -> pops give 32767/sat=1, -32768/sat=1, -500/sat=0 in order; sat_count=2 when PRED_SATCNT_EN is defined.
REQ-030 Hold out_ready=0 and push 6 samples -> in_ready=0 after the 4th push, count=4, and samples 5-6 are never output.
REQ-031 At count=2, push and pop in the same cycle -> count stays 2, and the pop returns the older sample.
REQ-032 Drop rst_n asynchronously at count=3 -> count=0 and out_valid=0 immediately; after release, push 7 -> first pop returns 7.
REQ-033 Empty buffer with out_ready=1 held for 5 cycles -> count stays 0, out_y=0, no underflow.

Source files
------------

// File: rtl/prediction_buffer.sv
// Saturating FIFO between the regression stage and downstream consumers.
// Optional PRED_SATCNT_EN adds a sticky 16-bit count of clipped pushes.
module prediction_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [31:0]                in_y,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_y,
  output logic                       out_sat,
`ifdef PRED_SATCNT_EN
  output logic [15:0]                sat_count,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;

  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  // Saturation bounds evaluated in 33-bit signed so OUT_W up to 32 is exact.
  localparam logic signed [32:0] SatMax = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] SatMin = -(33'sd1 <<< (OUT_W - 1));

  logic [OUT_W-1:0] mem_y   [DEPTH];
  logic             mem_sat [DEPTH];

  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic             push, pop;
  logic signed [32:0] y_ext;
  logic [OUT_W-1:0] y_sat;
  logic             y_clip;

  assign in_ready  = (count_q != Full);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    y_ext  = 33'(signed'(in_y));
    y_sat  = in_y[OUT_W-1:0];
    y_clip = 1'b0;
    if (y_ext > SatMax) begin
      y_sat  = SatMax[OUT_W-1:0];
      y_clip = 1'b1;
    end else if (y_ext < SatMin) begin
      y_sat  = SatMin[OUT_W-1:0];
      y_clip = 1'b1;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately unreset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wptr_q]   <= y_sat;
      mem_sat[wptr_q] <= y_clip;
    end
  end

  assign out_y   = out_valid ? mem_y[rptr_q] : '0;
  assign out_sat = out_valid ? mem_sat[rptr_q] : 1'b0;
  assign count   = count_q;

`ifdef PRED_SATCNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  always_comb begin
    sat_count_d = sat_count_q;
    if (push && y_clip && (sat_count_q != 16'hFFFF)) sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count_q <= '0;
    else        sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_prediction_buffer.sv
// Randomized bench for prediction_buffer against a queue-based reference model.
module tb_prediction_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OUT_W = 16;

  typedef struct {
    logic             sat;
    logic [OUT_W-1:0] y;
  } entry_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [31:0]       in_y;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_y;
  logic              out_sat;
  logic [$clog2(DEPTH):0] count;
`ifdef PRED_SATCNT_EN
  logic [15:0]       sat_count;
`endif

  int     n_cmp;
  int     n_bad;
  entry_t model_q[$];
  int     model_satcnt;

  prediction_buffer #(.DEPTH(DEPTH), .OUT_W(OUT_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_y      (in_y),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sat   (out_sat),
`ifdef PRED_SATCNT_EN
    .sat_count (sat_count),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp,
               $time);
    end
  endtask

  function automatic entry_t saturate(input logic [31:0] y);
    entry_t e;
    longint s;
    longint hi;
    longint lo;
    longint r;
    s  = longint'($signed(y));
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (s > hi) begin
      r = hi; e.sat = 1'b1;
    end else if (s < lo) begin
      r = lo; e.sat = 1'b1;
    end else begin
      r = s;  e.sat = 1'b0;
    end
    e.y = r[OUT_W-1:0];
    return e;
  endfunction

  task automatic compare_all();
    int sz;
    sz = model_q.size();
    check("count", 32'(count), 32'(sz));
    check("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    check("out_valid", 32'(out_valid), 32'(sz != 0));
    check("out_y", 32'(out_y), (sz != 0) ? 32'(model_q[0].y) : 32'd0);
    check("out_sat", 32'(out_sat), (sz != 0) ? 32'(model_q[0].sat) : 32'd0);
`ifdef PRED_SATCNT_EN
    check("sat_count", 32'(sat_count), 32'(model_satcnt));
`endif
  endtask

  // Check at the falling edge, then drive one cycle of stimulus and advance the model.
  task automatic step(input logic v, input logic [31:0] y, input logic r);
    logic   do_push;
    logic   do_pop;
    entry_t e;
    @(negedge clk);
    compare_all();
    in_valid  = v;
    in_y      = y;
    out_ready = r;
    do_push = v && (model_q.size() != DEPTH);
    do_pop  = r && (model_q.size() != 0);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      e = saturate(y);
      model_q.push_back(e);
      if (e.sat && model_satcnt < 65535) model_satcnt++;
    end
  endtask

  // Constant-valued check just after the edge that follows the last step.
  task automatic chk_head(input string tag, input logic v, input logic [15:0] y, input logic s,
                          input int c);
    #6;
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".y"}, 32'(out_y), 32'(y));
    check({tag, ".sat"}, 32'(out_sat), 32'(s));
    check({tag, ".count"}, 32'(count), 32'(c));
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'd0, 1'b1);
  endtask

  function automatic logic [31:0] rand_y();
    logic [15:0] b;
    logic [31:0] edges [6];
    edges[0] = 32'd32767;
    edges[1] = 32'd32768;
    edges[2] = 32'hFFFF_8000;
    edges[3] = 32'hFFFF_7FFF;
    edges[4] = 32'h7FFF_FFFF;
    edges[5] = 32'h8000_0000;
    b = 16'($urandom);
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return {{16{b[15]}}, b};
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    model_satcnt = 0;
    in_valid     = 1'b0;
    in_y         = 32'd0;
    out_ready    = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("rst.count", 32'(count), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_y", 32'(out_y), 32'd0);
    check("rst.out_sat", 32'(out_sat), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single push becomes visible one cycle later.
    step(1'b1, 32'd1000, 1'b0);
    chk_head("push1000", 1'b1, 16'd1000, 1'b0, 1);
    drain();

    // Saturation in both directions, then an in-range negative.
    step(1'b1, 32'd5000000, 1'b0);
    step(1'b1, -32'sd5000000, 1'b0);
    step(1'b1, -32'sd500, 1'b0);
    chk_head("sat0", 1'b1, 16'h7FFF, 1'b1, 3);
`ifdef PRED_SATCNT_EN
    check("satcnt2", 32'(sat_count), 32'd2);
`endif
    step(1'b0, 32'd0, 1'b1);
    chk_head("sat1", 1'b1, 16'h8000, 1'b1, 2);
    step(1'b0, 32'd0, 1'b1);
    chk_head("sat2", 1'b1, 16'hFE0C, 1'b0, 1);
    step(1'b0, 32'd0, 1'b1);
    chk_head("sat3", 1'b0, 16'd0, 1'b0, 0);

    // Overfill: pushes 5 and 6 are dropped.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i * 11), 1'b0);
    #6;
    check("full.in_ready", 32'(in_ready), 32'd0);
    check("full.count", 32'(count), 32'd4);
    step(1'b1, 32'd55, 1'b0);
    step(1'b1, 32'd66, 1'b1);
    drain();

    // Push and pop together at count 2.
    step(1'b1, 32'd21, 1'b0);
    step(1'b1, 32'd22, 1'b0);
    step(1'b1, 32'd23, 1'b1);
    chk_head("pushpop", 1'b1, 16'd22, 1'b0, 2);
    drain();

    // Popping an empty buffer.
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
    chk_head("empty", 1'b0, 16'd0, 1'b0, 0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), rand_y(), 1'($urandom_range(0, 99) < 50));
    drain();

    // Asynchronous reset mid-operation at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(100 + i), 1'b0);
    @(negedge clk);
    compare_all();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.count", 32'(count), 32'd0);
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.out_y", 32'(out_y), 32'd0);
    model_q.delete();
    model_satcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'd7, 1'b0);
    chk_head("after_rst", 1'b1, 16'd7, 1'b0, 1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);
    @(negedge clk);
    compare_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
